// File: rtl/ls_pkg.sv
// Shared types for the LS-stage access unit: FSM state encoding and RV load/store funct3 codes.
package ls_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    MISAL = 3'd3,
    DONE  = 3'd4
  } ls_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/ls_data_align.sv
// Combinational byte-lane logic: alignment check, store shift/strobe, load extract/extend.
module ls_data_align
  import ls_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic            aligned,
  output logic [XLEN-1:0] wdata,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      mask;
  logic            sext;

  assign wdata   = store_data << {offset, 3'b000};
  assign shifted = rdata >> {offset, 3'b000};
  assign sext    = ~funct3[2];
  assign wstrb   = mask << offset;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    aligned   = 1'b0;
    mask      = 8'h00;
    load_data = '0;
    case (funct3[1:0])
      2'd0: begin
        aligned   = 1'b1;
        mask      = 8'h01;
        load_data = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        aligned   = (offset[0] == 1'b0);
        mask      = 8'h03;
        load_data = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
      end
      2'd2: begin
        aligned   = (offset[1:0] == 2'b00);
        mask      = 8'h0F;
        load_data = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
      end
      default: begin
        aligned   = (offset == 3'b000);
        mask      = 8'hFF;
        load_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/ls_access_unit.sv
// LS-stage access unit: runs one data-memory bus transaction per EX/LS instruction and pulses ls_valid on completion.
module ls_access_unit
  import ls_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_ls_valid,
  input  logic            load_flag,
  input  logic            store_flag,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wstrb,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_rdata,
  output logic            ls_valid,
  output logic [XLEN-1:0] load_data,
  output logic            ls_misalign
);

  ls_state_e       state_q, state_d;
  logic [2:0]      off_q;
  logic [2:0]      funct3_q;
  logic            is_load_q;
  logic            active;
  logic            in_idle;
  logic [2:0]      al_off;
  logic [2:0]      al_funct3;
  logic            al_aligned;
  logic [XLEN-1:0] al_wdata;
  logic [7:0]      al_wstrb;
  logic [XLEN-1:0] al_load_data;

  assign active  = ex_ls_valid & (load_flag | store_flag);
  assign in_idle = (state_q == IDLE);

  // The aligner sees live inputs while issuing and the held offset/size while the load is in flight.
  assign al_off    = in_idle ? addr[2:0] : off_q;
  assign al_funct3 = in_idle ? funct3    : funct3_q;

  ls_data_align #(.XLEN(XLEN)) u_align (
    .offset     (al_off),
    .funct3     (al_funct3),
    .store_data (store_data),
    .rdata      (mem_resp_rdata),
    .aligned    (al_aligned),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .load_data  (al_load_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (active) state_d = al_aligned ? REQ : MISAL;
      REQ:     if (mem_req_ready) state_d = WAIT;
      WAIT:    if (mem_resp_valid) state_d = DONE;
      MISAL:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the datapath registers are reset too, because the bus and monitor see them as outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      ls_valid      <= 1'b0;
      load_data     <= '0;
      ls_misalign   <= 1'b0;
      off_q         <= '0;
      funct3_q      <= '0;
      is_load_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_valid <= (state_d == REQ);
      ls_valid      <= (state_d == DONE);

      if (in_idle && active) begin
        mem_req_wen   <= store_flag;
        mem_req_addr  <= {addr[XLEN-1:3], 3'b000};
        mem_req_wdata <= (store_flag && al_aligned) ? al_wdata : '0;
        mem_req_wstrb <= (store_flag && al_aligned) ? al_wstrb : 8'h00;
        off_q         <= addr[2:0];
        funct3_q      <= funct3;
        is_load_q     <= load_flag;
        load_data     <= '0;
        ls_misalign   <= ~al_aligned;
      end

      if ((state_q == WAIT) && mem_resp_valid && is_load_q) begin
        load_data <= al_load_data;
      end
    end
  end

endmodule
